pipe_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage core. Drives the 6-bit stall vector consumed by PC, IF_ID, ID_EX, EX_MEM, MEM_WB and WB.
- Sequences multi-cycle EX operations (divider) with a watchdog timeout.
- On an exception or ERET from MEM, issues the flush and the redirect PC.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_ctrl_sat_counter.sv | 35 +++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stall encodings, exception codes and
// the controller state type. Imported by the stage registers as well.
package pipe_pkg;

   // Per-stage stall bit meaning
   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Stall vector encodings: bit0 PC .. bit5 WB
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   // Exception type that returns to the saved EPC instead of the vector
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      EX_WAIT = 1'b1
   } ctrl_state_e;

   // True when the MEM-stage exception is a return-from-exception
   function automatic logic is_eret(input logic [31:0] excptype);
      return (excptype == EXC_ERET);
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, then increment unless already at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, multi-cycle EX sequencing with
// watchdog, exception/ERET flush and redirect, stall-cycle performance counter.
// Control outputs are combinational so ID_EX can form a bubble in the same cycle.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
   parameter int          EX_TIMEOUT = 64,   // must be >= 2
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id_i,
   input  logic             ex_start_i,
   input  logic             ex_done_i,
   input  logic             stallreq_mem_i,
   input  logic [31:0]      excptype_i,
   input  logic [31:0]      epc_i,
   output logic [5:0]       stall_o,
   output logic             flush_o,
   output logic [31:0]      new_pc_o,
   output logic             ex_abort_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int              WAIT_W    = $clog2(EX_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EX_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

   ctrl_state_e       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic        exc_s;
   logic [5:0]  stall_s;
   logic        flush_s;
   logic [31:0] new_pc_s;
   logic        abort_s;
   logic        timeout_s;

   assign exc_s = (excptype_i != 32'h0000_0000);

   // Next state, wait counter and control outputs, in priority order:
   // exception > watchdog > mem stall > EX wait > ID stall
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      stall_s   = STALL_NONE;
      flush_s   = 1'b0;
      new_pc_s  = 32'h0000_0000;
      abort_s   = 1'b0;
      timeout_s = 1'b0;
      if (rst) begin
         // Outputs stay at zero; an in-flight op is dropped without abort
         state_d = RUN;
         wait_d  = '0;
      end else if (exc_s) begin
         flush_s  = 1'b1;
         new_pc_s = is_eret(excptype_i) ? epc_i : EXC_VECTOR;
         abort_s  = (state_q == EX_WAIT);
         state_d  = RUN;
         wait_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               wait_d = '0;
               if (ex_start_i) begin
                  // Op is accepted even under a mem stall; the stall vector
                  // just reflects the stronger mem request this cycle
                  state_d = EX_WAIT;
                  stall_s = stallreq_mem_i ? STALL_MEM : STALL_EX;
               end else if (stallreq_mem_i) begin
                  stall_s = STALL_MEM;
               end else if (stallreq_id_i) begin
                  stall_s = STALL_ID;
               end else begin
                  stall_s = STALL_NONE;
               end
            end
            EX_WAIT: begin
               if (ex_done_i) begin
                  // Done pulse is consumed even if mem is stalling
                  state_d = RUN;
                  wait_d  = '0;
                  stall_s = stallreq_mem_i ? STALL_MEM : STALL_NONE;
               end else if (wait_q == WAIT_LAST) begin
                  timeout_s = 1'b1;
                  abort_s   = 1'b1;
                  flush_s   = 1'b1;
                  new_pc_s  = EXC_VECTOR;
                  state_d   = RUN;
                  wait_d    = '0;
               end else if (stallreq_mem_i) begin
                  // Watchdog time does not elapse while memory holds the pipe
                  stall_s = STALL_MEM;
                  wait_d  = wait_q;
               end else begin
                  stall_s = STALL_EX;
                  wait_d  = wait_q + WAIT_ONE;
               end
            end
            default: begin
               state_d = RUN;
               wait_d  = '0;
            end
         endcase
      end
   end

   // State and watchdog counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (stall_s != STALL_NONE),
      .cnt_o (stall_cnt_o)
   );

   assign stall_o    = stall_s;
   assign flush_o    = flush_s;
   assign new_pc_o   = new_pc_s;
   assign ex_abort_o = abort_s;
   assign timeout_o  = timeout_s;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed table, multi-cycle sequences
// and randomized traffic compared against a behavioural model.
module tb_pipe_ctrl;
   import pipe_pkg::*;

   localparam int          EX_TIMEOUT = 64;
   localparam int          CNT_W      = 32;
   localparam logic [31:0] VEC        = 32'h0000_0040;

   logic             clk = 1'b0;
   logic             rst;
   logic             stallreq_id_i, ex_start_i, ex_done_i, stallreq_mem_i;
   logic [31:0]      excptype_i, epc_i;
   logic [5:0]       stall_o;
   logic             flush_o, ex_abort_o, timeout_o;
   logic [31:0]      new_pc_o;
   logic [CNT_W-1:0] stall_cnt_o;

   always #5 clk = ~clk;

   pipe_ctrl #(.EXC_VECTOR(VEC), .EX_TIMEOUT(EX_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .stallreq_id_i(stallreq_id_i), .ex_start_i(ex_start_i), .ex_done_i(ex_done_i),
      .stallreq_mem_i(stallreq_mem_i), .excptype_i(excptype_i), .epc_i(epc_i),
      .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .ex_abort_o(ex_abort_o), .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
   );

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        abort;
      logic        tmo;
      logic [31:0] cnt;
   } obs_t;

   typedef struct {
      logic        r, id, st, dn, mem;
      logic [31:0] exc, epc;
      obs_t        exp;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Model: busy flag, EX_WAIT cycles elapsed (not counting mem stalls), stall count
   bit          m_busy = 1'b0;
   int          m_wait = 0;
   longint      m_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic obs_t model_out();
      obs_t e;
      e = '0;
      e.cnt = m_cnt[31:0];
      if (rst) return e;
      if (excptype_i != 32'd0) begin
         e.flush = 1'b1;
         e.pc    = (excptype_i == 32'h0000_000e) ? epc_i : VEC;
         e.abort = m_busy;
      end else if (m_busy && m_wait == EX_TIMEOUT - 1 && !ex_done_i) begin
         e.tmo = 1'b1; e.abort = 1'b1; e.flush = 1'b1; e.pc = VEC;
      end else if (stallreq_mem_i) begin
         e.stall = 6'h1f;
      end else if (m_busy ? !ex_done_i : ex_start_i) begin
         e.stall = 6'h0f;
      end else if (!m_busy && stallreq_id_i) begin
         e.stall = 6'h07;
      end
      return e;
   endfunction

   task automatic model_advance(input obs_t e);
      if (rst) begin
         m_busy = 1'b0; m_wait = 0; m_cnt = 0;
      end else begin
         if (e.stall != 6'd0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (excptype_i != 32'd0 || e.tmo) begin
            m_busy = 1'b0; m_wait = 0;
         end else if (m_busy) begin
            if (ex_done_i) begin
               m_busy = 1'b0; m_wait = 0;
            end else if (!stallreq_mem_i) begin
               m_wait++;
            end
         end else if (ex_start_i) begin
            m_busy = 1'b1; m_wait = 0;
         end
      end
   endtask

   // One cycle: drive on negedge, compare against model, advance model at posedge
   task automatic apply(input logic r, id, st, dn, mem, input logic [31:0] exc, epc,
                        output obs_t o);
      obs_t e;
      @(negedge clk);
      rst = r; stallreq_id_i = id; ex_start_i = st; ex_done_i = dn;
      stallreq_mem_i = mem; excptype_i = exc; epc_i = epc;
      #1;
      e = model_out();
      o = '{stall_o, flush_o, new_pc_o, ex_abort_o, timeout_o, stall_cnt_o};
      chk("m_stall", {26'd0, o.stall}, {26'd0, e.stall});
      chk("m_flush", {31'd0, o.flush}, {31'd0, e.flush});
      chk("m_newpc", o.pc, e.pc);
      chk("m_abort", {31'd0, o.abort}, {31'd0, e.abort});
      chk("m_timeout", {31'd0, o.tmo}, {31'd0, e.tmo});
      chk("m_cnt", o.cnt, e.cnt);
      @(posedge clk);
      model_advance(e);
   endtask

   task automatic idle(output obs_t o);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
   endtask

   // The bench itself must never issue ex_start_i while an op is in flight
   always @(posedge clk) begin
      if (!rst && dut.state_q == EX_WAIT) begin
         assert (!ex_start_i) else $error("illegal ex_start_i while busy");
      end
   end

   vec_t tbl[19];
   obs_t o;

   initial begin
      rst = 1'b1; stallreq_id_i = 1'b0; ex_start_i = 1'b0; ex_done_i = 1'b0;
      stallreq_mem_i = 1'b0; excptype_i = 32'd0; epc_i = 32'd0;
      repeat (2) @(posedge clk);

      //            r  id st dn mem exc         epc          stall  fl pc          ab to cnt
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd0}};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd0}};
      tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h07,1'b0,32'h0,1'b0,1'b0,32'd0}};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd1}};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'he,32'h1234, '{6'h00,1'b1,32'h1234,1'b0,1'b0,32'd1}};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,    '{6'h1f,1'b0,32'h0,1'b0,1'b0,32'd1}};
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,    '{6'h0f,1'b0,32'h0,1'b0,1'b0,32'd2}};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h8,32'h0,    '{6'h00,1'b1,32'h40,1'b1,1'b0,32'd3}};
      tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h07,1'b0,32'h0,1'b0,1'b0,32'd3}};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd4}};
      tbl[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,32'h0,    '{6'h0f,1'b0,32'h0,1'b0,1'b0,32'd4}};
      tbl[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h0f,1'b0,32'h0,1'b0,1'b0,32'd5}};
      tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,    '{6'h1f,1'b0,32'h0,1'b0,1'b0,32'd6}};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd7}};
      tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd7}};
      tbl[15] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd7}};
      tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h00,1'b0,32'h0,1'b0,1'b0,32'd0}};
      tbl[17] = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h3,32'h0,    '{6'h00,1'b1,32'h40,1'b0,1'b0,32'd0}};
      tbl[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,    '{6'h07,1'b0,32'h0,1'b0,1'b0,32'd0}};

      for (int i = 0; i < 19; i++) begin
         apply(tbl[i].r, tbl[i].id, tbl[i].st, tbl[i].dn, tbl[i].mem, tbl[i].exc, tbl[i].epc, o);
         chk($sformatf("tbl%0d_outs", i), {o.stall, o.flush, o.abort, o.tmo},
             {tbl[i].exp.stall, tbl[i].exp.flush, tbl[i].exp.abort, tbl[i].exp.tmo});
         chk($sformatf("tbl%0d_pc", i), o.pc, tbl[i].exp.pc);
         chk($sformatf("tbl%0d_cnt", i), o.cnt, tbl[i].exp.cnt);
      end

      // Divide: start at cycle 0, done at cycle 10
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
      for (int k = 0; k <= 10; k++) begin
         apply(1'b0, 1'b0, (k == 0), (k == 10), 1'b0, 32'd0, 32'd0, o);
         chk($sformatf("div_stall%0d", k), {26'd0, o.stall}, (k < 10) ? 32'h0f : 32'h00);
      end
      idle(o);
      chk("div_cnt", o.cnt, 32'd10);

      // Watchdog: fires on the 64th EX_WAIT cycle, then back in RUN
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, o);
      for (int k = 0; k < EX_TIMEOUT; k++) begin
         idle(o);
         chk($sformatf("wd_tmo%0d", k), {31'd0, o.tmo}, (k == EX_TIMEOUT - 1) ? 32'd1 : 32'd0);
      end
      chk("wd_abort_flush", {30'd0, o.abort, o.flush}, 32'd3);
      chk("wd_newpc", o.pc, 32'h40);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
      chk("wd_after_run", {26'd0, o.stall}, 32'h07);

      // Watchdog is frozen during mem stalls
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, o);
      for (int j = 0; j < 5; j++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, o);
         chk($sformatf("frz_mem%0d", j), {26'd0, o.stall}, 32'h1f);
      end
      for (int k = 0; k < EX_TIMEOUT; k++) begin
         idle(o);
         chk($sformatf("frz_tmo%0d", k), {31'd0, o.tmo}, (k == EX_TIMEOUT - 1) ? 32'd1 : 32'd0);
      end

      // Reset mid-op: silent abandon, later done has no effect
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, o);
      repeat (3) idle(o);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
      chk("rst_outs", {o.stall, o.flush, o.abort, o.tmo}, 9'd0);
      chk("rst_pc", o.pc, 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, o);
      chk("rst_done_stall", {26'd0, o.stall}, 32'h00);
      chk("rst_cnt", o.cnt, 32'd0);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
      chk("rst_run", {26'd0, o.stall}, 32'h07);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic        r, id, st, dn, mem;
         logic [31:0] exc, epc;
         r   = ($urandom_range(63) == 0);
         id  = ($urandom_range(3) == 0);
         mem = ($urandom_range(5) == 0);
         st  = !m_busy && ($urandom_range(5) == 0);
         dn  = m_busy ? ($urandom_range(9) == 0) : ($urandom_range(19) == 0);
         epc = $urandom;
         if ($urandom_range(15) == 0) begin
            exc = ($urandom_range(2) == 0) ? 32'h0000_000e : ($urandom | 32'h1);
         end else begin
            exc = 32'd0;
         end
         apply(r, id, st, dn, mem, exc, epc, o);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
